aes_round_ctrl: RTL and testbench

//  Iterative AES-128 encryption controller: one round per clock through the SubBytes/ShiftRows/MixColumns/AddRoundKey datapath.

---
 rtl/aes_pkg.sv | 77 +++++++
 rtl/aes_key_step.sv | 30 +++
 rtl/aes_round_ctrl.sv | 113 +++++++++++
 tb/tb_aes_round_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: round constants, FSM encoding and the byte-level
// transforms (xtime, GF multiply, S-box, SubBytes/ShiftRows/MixColumns).
// State byte n lives at bits [127-8n -: 8] of a [127:0] vector (byte 0 leftmost).
package aes_pkg;

    localparam int         NR_AES128 = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam int         STATE_W   = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as b^254 (0 maps to 0), followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] inv;
        logic [7:0] base;
        inv  = 8'h01;
        base = b;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            inv  = gf_mul(inv, base);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    // Row r of column c takes the byte from column (c+r) mod 4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One step of the AES-128 key schedule: RotWord/SubWord/Rcon applied to word 3,
// then the running XOR chain across words 0..3. Purely combinational.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [127:0] i_rk,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_nk
);

    logic [31:0] w_w0, w_w1, w_w2, w_w3;
    logic [31:0] w_temp;
    logic [31:0] w_n0, w_n1, w_n2, w_n3;

    assign w_w0 = i_rk[127:96];
    assign w_w1 = i_rk[95:64];
    assign w_w2 = i_rk[63:32];
    assign w_w3 = i_rk[31:0];

    assign w_temp = {sbox(w_w3[23:16]), sbox(w_w3[15:8]), sbox(w_w3[7:0]), sbox(w_w3[31:24])}
                    ^ {i_rcon, 24'h000000};

    assign w_n0 = w_w0 ^ w_temp;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    assign o_nk = {w_n0, w_n1, w_n2, w_n3};

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryptor: one full round per clock, on-the-fly key expansion,
// valid/ready on both sides. Optional abort input enabled by `define AES_ABORT_EN.
// round_idx holds NR while the result waits in DONE and returns to 0 on the way to IDLE.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int         NR        = aes_pkg::NR_AES128,
    parameter logic [7:0] RCON_INIT = aes_pkg::RCON_INIT
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] plaintext,
    input  logic [0:127] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] ciphertext,
    output logic         busy,
    output logic [3:0]   round_idx
);

    localparam logic [3:0] NR_L = 4'(NR);

    aes_state_e           r_fsm;
    logic [STATE_W-1:0]   r_state;
    logic [STATE_W-1:0]   r_rk;
    logic [STATE_W-1:0]   r_ct;
    logic [7:0]           r_rcon;
    logic [3:0]           r_round;
    logic                 r_out_valid;

    logic [STATE_W-1:0]   w_nk;
    logic [STATE_W-1:0]   w_sr;
    logic [STATE_W-1:0]   w_mix;
    logic [STATE_W-1:0]   w_next;
    logic                 w_abort;

`ifdef AES_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    aes_key_step u_key_step (
        .i_rk   (r_rk),
        .i_rcon (r_rcon),
        .o_nk   (w_nk)
    );

    assign w_sr   = shift_rows(sub_bytes(r_state));
    assign w_mix  = mix_columns(w_sr);
    assign w_next = ((r_round == NR_L) ? w_sr : w_mix) ^ w_nk;

    assign in_ready   = (r_fsm == IDLE);
    assign busy       = (r_fsm == ROUND);
    assign out_valid  = r_out_valid;
    assign ciphertext = r_ct;
    assign round_idx  = r_round;

    // Control FSM plus state/key/rcon registers: accept, iterate rounds, hold result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_ct        <= '0;
            r_rcon      <= RCON_INIT;
            r_round     <= 4'd0;
            r_out_valid <= 1'b0;
        end else if (w_abort && (r_fsm != IDLE)) begin
            r_fsm       <= IDLE;
            r_out_valid <= 1'b0;
            r_round     <= 4'd0;
        end else begin
            case (r_fsm)
                IDLE: begin
                    if (in_valid) begin
                        r_state <= plaintext ^ key;
                        r_rk    <= key;
                        r_round <= 4'd1;
                        r_rcon  <= RCON_INIT;
                        r_fsm   <= ROUND;
                    end
                end
                ROUND: begin
                    r_state <= w_next;
                    r_rk    <= w_nk;
                    r_rcon  <= xtime(r_rcon);
                    if (r_round == NR_L) begin
                        r_ct        <= w_next;
                        r_out_valid <= 1'b1;
                        r_fsm       <= DONE;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_round     <= 4'd0;
                        r_fsm       <= IDLE;
                    end
                end
                default: r_fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: known-answer vectors, random blocks against
// an array-based AES-128 model, backpressure, mid-operation reset and (with
// AES_ABORT_EN) abort behaviour.
module tb_aes_round_ctrl;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [0:127] plaintext = '0;
    logic [0:127] key = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [0:127] ciphertext;
    logic [3:0]   round_idx;
`ifdef AES_ABORT_EN
    logic         abort = 1'b0;
`endif

    always #5 clk = ~clk;

    aes_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy),
        .round_idx  (round_idx)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_hs    = 0;

    always @(posedge clk) if (out_valid && out_ready) n_hs++;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sb [256];

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int s);
        logic [15:0] d;
        d = {x, x} << s;
        return d[15:8];
    endfunction

    function automatic logic [7:0] m2(input logic [7:0] x);
        return (x << 1) ^ ((x & 8'h80) != 0 ? 8'h1b : 8'h00);
    endfunction

    // S-box via generator 3 / inverse 0xf6 walk over the multiplicative group.
    task automatic gen_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] k);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
                rc = m2(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int n = 0; n < 16; n++) u[n] = sb[s[n]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++) s[rr+4*c] = u[rr+4*((c+rr)%4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
                    s[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = s[n] ^ w[4*r + n/4][31-8*(n%4) -: 8];
        end
        for (int n = 0; n < 16; n++) o[127-8*n -: 8] = s[n];
        return o;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_in_ready();
        int g = 0;
        while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
        if (g >= 50) chk("in_ready_timeout", 0, 1);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) chk("out_valid_timeout", 0, 1);
    endtask

    task automatic run_block(input logic [127:0] p, input logic [127:0] k,
                             input logic [127:0] exp, input int stall,
                             output logic [127:0] ct_got, output int lat);
        int hs0;
        wait_in_ready();
        in_valid  = 1'b1;
        plaintext = p;
        key       = k;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
        key       = {$urandom(), $urandom(), $urandom(), $urandom()};
        hs0 = n_hs;
        wait_out_valid(lat);
        ct_got = ciphertext;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            chk("hold_ct", ciphertext, exp);
            chk("hold_out_valid", out_valid, 1);
        end
        chk("in_ready_in_done", in_ready, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_out_valid", out_valid, 0);
        chk("post_hs_in_ready", in_ready, 1);
        chk("one_handshake", n_hs - hs0, 1);
    endtask

    typedef struct {
        logic [127:0] pt;
        logic [127:0] key;
        logic [127:0] ct;
        int           stall;
    } vec_t;

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    initial begin
        vec_t         tbl [8];
        logic [127:0] got;
        int           lat;
        int           hs0;

        gen_sbox();
        tbl[0] = '{PT_B, KEY_B, CT_B, 5};
        tbl[1] = '{PT_C, KEY_C, CT_C, 0};
        for (int i = 2; i < 8; i++) begin
            tbl[i].pt    = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i].key   = {$urandom(), $urandom(), $urandom(), $urandom()};
            tbl[i].ct    = ref_aes(tbl[i].pt, tbl[i].key);
            tbl[i].stall = $urandom_range(0, 3);
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_ciphertext", ciphertext, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // round-1 MixColumns probe, then reset at round 5
        hs0 = n_hs;
        in_valid  = 1'b1;
        plaintext = PT_B;
        key       = KEY_B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("acc_round_idx", round_idx, 1);
        chk("acc_busy", busy, 1);
        chk("acc_in_ready", in_ready, 0);
        chk("round1_mix", dut.w_mix, 128'h046681e5e0cb199a48f8d37a2806264c);
        repeat (4) @(posedge clk);
        #1;
        chk("round5_idx", round_idx, 5);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_round_idx", round_idx, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("midrst_no_output", n_hs - hs0, 0);
        chk("midrst_still_idle", out_valid, 0);

        // table-driven known-answer and random blocks
        for (int i = 0; i < 8; i++) begin
            run_block(tbl[i].pt, tbl[i].key, tbl[i].ct, tbl[i].stall, got, lat);
            chk($sformatf("ct[%0d]", i), got, tbl[i].ct);
            chk($sformatf("latency[%0d]", i), lat, 10);
        end

`ifdef AES_ABORT_EN
        begin
            logic seen;
            hs0 = n_hs;
            wait_in_ready();
            in_valid  = 1'b1;
            plaintext = PT_B;
            key       = KEY_B;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk("abort_at_round3", round_idx, 3);
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            chk("abort_in_ready", in_ready, 1);
            chk("abort_busy", busy, 0);
            chk("abort_round_idx", round_idx, 0);
            seen = 1'b0;
            for (int i = 0; i < 15; i++) begin
                if (out_valid) seen = 1'b1;
                @(posedge clk); #1;
            end
            chk("abort_no_out_valid", seen, 0);
            chk("abort_no_handshake", n_hs - hs0, 0);

            abort     = 1'b1;
            in_valid  = 1'b1;
            plaintext = PT_C;
            key       = KEY_C;
            @(posedge clk); #1;
            abort    = 1'b0;
            in_valid = 1'b0;
            chk("abort_idle_accept", busy, 1);
            wait_out_valid(lat);
            chk("abort_idle_ct", ciphertext, CT_C);
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;

            run_block(PT_B, KEY_B, CT_B, 0, got, lat);
            chk("after_abort_ct", got, CT_B);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
